sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

Downstream of the UART-to-SHA block buffer: captures each completed 512-bit message block and expands it into the 64 SHA-256 message-schedule words W0..W63. Words are issued one per cycle to the compression core over a valid/ready handshake. The block holds a 16-word sliding window, so no 64-word RAM is needed. An optional one-block skid slot absorbs a block that arrives while the current expansion is in progress.

## Interface
- No parameters; word width (32), window depth (16) and round count (64) are fixed by SHA-256.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- sha_block  in  512  message block; first received byte in [511:504]
- block_ready  in  1  one-cycle pulse; sha_block valid this cycle
- w_valid  out  1  w_out/w_idx/w_last valid
- w_ready  in  1  core accepts current word
- w_out  out  32  schedule word W[w_idx]
- w_idx  out  6  round index t, 0..63
- w_last  out  1  high while w_idx==63 and w_valid
- busy  out  1  RUN state, or skid slot occupied
- block_drop  out  1  one-cycle pulse: incoming block discarded

## Operation
- States: IDLE and RUN.
- Block load:
  - window[i] <= sha_block[511-32i -: 32], i=0..15.
  - t <= 0, state <= RUN.
- In RUN, w_out = window[0] and w_idx = t.
- Handshake fires when w_valid && w_ready:
  - window[i] <= window[i+1] for i=0..14.
  - window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], computed mod 2^32 with carries discarded.
  - t <= t+1.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Handshake at t==63: state <= IDLE, unless a new block is loaded in the same cycle (see boundaries).
- No handshake: window, t and w_out hold unchanged.
- block_ready accepted directly when:
  - state is IDLE, or
  - the final (t==63) handshake occurs in the same cycle.
- block_ready during RUN at any other time:
  - Skid slot empty: block stored, no drop.
  - Otherwise: block_drop pulses and the block is discarded.
- Skid slot occupied at the final handshake: the slot is loaded into the window and the slot is freed. If block_ready is also high that cycle, the new block goes into the slot.

## Timing
- Reset values: w_valid=0, w_out=0, w_idx=0, w_last=0, busy=0, block_drop=0, window cleared, skid empty, state=IDLE.
- rst asserted mid-expansion aborts immediately. Outputs are cleared asynchronously and the partial block is not resumed.
- block_ready at cycle N (IDLE) -> w_valid=1 with W0 at N+1.
- With w_ready held high, W0..W63 are issued on cycles N+1..N+64 with no bubbles.
- Back-to-back blocks (new block loaded in the same cycle as the t==63 handshake) -> next block's W0 issues the following cycle, no bubble.
- w_out, w_idx and w_last are registered and stable while w_valid=1 and w_ready=0.
- block_drop is registered; it pulses in the cycle after the discarded block_ready.

## Configuration
- SHA_SCHED_SKID_EN defined: one-block skid slot (512-bit register plus valid bit) is present. busy = RUN || slot_valid.
- SHA_SCHED_SKID_EN undefined: no slot. Every block_ready in RUN, other than one coinciding with the final handshake, is dropped with block_drop. busy = RUN.

## Test plan
- "abc" padded block (0x61626380, 13 zero words, 0x00000000, 0x00000018) with w_ready=1 -> the following words, then w_last at idx 63:
  - W0=0x61626380, W15=0x00000018
  - W16=0x61626380, W17=0x000F0000
- Same block with w_ready toggled pseudo-randomly -> identical 64-word sequence, and w_out is stable during every stall.
- Second block pulsed in the same cycle as the t==63 handshake -> its W0 issues the next cycle, and block_drop stays 0.
- Block pulsed at t=10, then another at t=20:
  - With SHA_SCHED_SKID_EN: the first is queued, the second gives a block_drop pulse, and the queued block issues after the current one's W63.
  - Without SHA_SCHED_SKID_EN: both give block_drop pulses.
- rst asserted at t=30 -> w_valid=0 and busy=0 immediately. A fresh block after reset starts again at W0/idx 0.
- All-ones block -> W16 = σ1(0xFFFFFFFF) + 0xFFFFFFFF + σ0(0xFFFFFFFF) + 0xFFFFFFFF mod 2^32, which checks carry wrap.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule expander, W0..W63 from a 16-word sliding window
// Optional one-block skid slot enabled by defining SHA_SCHED_SKID_EN.
module sha256_msg_schedule (
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] sha_block,
   input  logic         block_ready,
   output logic         w_valid,
   input  logic         w_ready,
   output logic [31:0]  w_out,
   output logic [5:0]   w_idx,
   output logic         w_last,
   output logic         busy,
   output logic         block_drop
);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [31:0]    r_window [16];
   logic [5:0]     r_t;
   logic           r_drop;

   logic           w_fire;
   logic           w_final;
   logic           w_load;
   logic [511:0]   w_load_block;
   logic           w_drop_nxt;
   logic [31:0]    w_new_word;

`ifdef SHA_SCHED_SKID_EN
   logic           r_skid_valid;
   logic [511:0]   r_skid_block;
   logic           w_skid_valid_nxt;
   logic           w_skid_we;
`endif

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      w_load_block = sha_block;
      w_drop_nxt   = 1'b0;
      w_fire       = (r_state == ST_RUN) && w_ready;
      w_final      = w_fire && (r_t == 6'd63);
      case (r_state)
         ST_IDLE: begin
            if (block_ready) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_final) begin
               if (block_ready) w_load = 1'b1;
`ifdef SHA_SCHED_SKID_EN
               // A queued block takes priority; a coincident new block refills the slot.
               if (r_skid_valid) begin
                  w_load       = 1'b1;
                  w_load_block = r_skid_block;
               end
`endif
               w_state_nxt = w_load ? ST_RUN : ST_IDLE;
            end else if (block_ready) begin
`ifdef SHA_SCHED_SKID_EN
               w_drop_nxt = r_skid_valid;
`else
               w_drop_nxt = 1'b1;
`endif
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef SHA_SCHED_SKID_EN
   always_comb begin
      w_skid_valid_nxt = r_skid_valid;
      w_skid_we        = 1'b0;
      if ((r_state == ST_RUN) && block_ready && !w_final && !r_skid_valid) begin
         w_skid_valid_nxt = 1'b1;
         w_skid_we        = 1'b1;
      end
      if (w_final && r_skid_valid) begin
         w_skid_valid_nxt = block_ready;
         w_skid_we        = block_ready;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_skid_valid <= 1'b0;
         r_skid_block <= '0;
      end else begin
         r_skid_valid <= w_skid_valid_nxt;
         if (w_skid_we) r_skid_block <= sha_block;
      end
   end
`endif

   assign w_new_word = sig1(r_window[14]) + r_window[9] + sig0(r_window[1]) + r_window[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) r_window[i] <= '0;
         r_t <= '0;
      end else if (w_load) begin
         for (int i = 0; i < 16; i++) r_window[i] <= w_load_block[511-32*i -: 32];
         r_t <= '0;
      end else if (w_fire) begin
         for (int i = 0; i < 15; i++) r_window[i] <= r_window[i+1];
         r_window[15] <= w_new_word;
         r_t          <= r_t + 6'd1;
      end
   end

   assign w_valid    = (r_state == ST_RUN);
   assign w_out      = r_window[0];
   assign w_idx      = r_t;
   assign w_last     = w_valid && (r_t == 6'd63);
   assign block_drop = r_drop;
`ifdef SHA_SCHED_SKID_EN
   assign busy = (r_state == ST_RUN) || r_skid_valid;
`else
   assign busy = (r_state == ST_RUN);
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - randomized self-checking bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [511:0] sha_block = '0;
   logic         block_ready = 1'b0;
   logic         w_valid;
   logic         w_ready = 1'b0;
   logic [31:0]  w_out;
   logic [5:0]   w_idx;
   logic         w_last;
   logic         busy;
   logic         block_drop;

   int           n_total = 0;
   int           n_bad = 0;
   logic [31:0]  exp_q [$];
   int           exp_iq [$];
   logic [31:0]  cap [0:63];

   sha256_msg_schedule dut (
      .clk         (clk),
      .rst         (rst),
      .sha_block   (sha_block),
      .block_ready (block_ready),
      .w_valid     (w_valid),
      .w_ready     (w_ready),
      .w_out       (w_out),
      .w_idx       (w_idx),
      .w_last      (w_last),
      .busy        (busy),
      .block_drop  (block_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook SHA-256 schedule recurrence over a full 64-entry array.
   task automatic expect_block(input logic [511:0] b);
      logic [31:0] w [0:63];
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      for (int t = 0; t < 64; t++) begin
         exp_q.push_back(w[t]);
         exp_iq.push_back(t);
      end
   endtask

   task automatic load(input logic [511:0] b);
      sha_block   = b;
      block_ready = 1'b1;
      @(negedge clk);
      block_ready = 1'b0;
   endtask

   task automatic drain(input int n, input bit rnd,
                        input int inj1, input logic [511:0] b1, input bit d1,
                        input int inj2, input logic [511:0] b2, input bit d2,
                        output int cyc);
      int got = 0;
      int c = 0;
      bit exp_drop = 1'b0;
      while (got < n && c < n * 8 + 40) begin
         chk("block_drop", {63'd0, block_drop}, {63'd0, exp_drop});
         exp_drop    = 1'b0;
         block_ready = 1'b0;
         w_ready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (w_valid) begin
            chk("w_out", {32'd0, w_out}, {32'd0, exp_q[0]});
            chk("w_idx", {58'd0, w_idx}, 64'(exp_iq[0]));
            chk("w_last", {63'd0, w_last}, {63'd0, exp_iq[0] == 63});
            if (w_ready) begin
               if (got == inj1) begin block_ready = 1'b1; sha_block = b1; exp_drop = d1; end
               if (got == inj2) begin block_ready = 1'b1; sha_block = b2; exp_drop = d2; end
               cap[got % 64] = w_out;
               void'(exp_q.pop_front());
               void'(exp_iq.pop_front());
               got++;
            end
         end
         @(negedge clk);
         c++;
      end
      block_ready = 1'b0;
      if (got < n) chk("timeout", 64'(got), 64'(n));
      chk("block_drop_end", {63'd0, block_drop}, {63'd0, exp_drop});
      cyc = c;
   endtask

   initial begin
      logic [511:0] abc, ones, ra, rb, rc;
      int           cyc;

      abc  = {32'h61626380, 416'd0, 32'h0, 32'h18};
      ones = {512{1'b1}};

      // reset state
      @(negedge clk);
      chk("rst_w_valid", {63'd0, w_valid}, 64'd0);
      chk("rst_w_out", {32'd0, w_out}, 64'd0);
      chk("rst_w_idx", {58'd0, w_idx}, 64'd0);
      chk("rst_w_last", {63'd0, w_last}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_block_drop", {63'd0, block_drop}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // "abc" with w_ready held high
      expect_block(abc);
      load(abc);
      chk("busy_run", {63'd0, busy}, 64'd1);
      drain(64, 1'b0, -1, '0, 1'b0, -1, '0, 1'b0, cyc);
      chk("abc_cycles", 64'(cyc), 64'd64);
      chk("abc_w0", {32'd0, cap[0]}, 64'h61626380);
      chk("abc_w15", {32'd0, cap[15]}, 64'h18);
      chk("abc_w16", {32'd0, cap[16]}, 64'h61626380);
      chk("abc_w17", {32'd0, cap[17]}, 64'h000F0000);
      chk("abc_idle_valid", {63'd0, w_valid}, 64'd0);
      chk("abc_idle_busy", {63'd0, busy}, 64'd0);

      // "abc" with random backpressure
      expect_block(abc);
      load(abc);
      drain(64, 1'b1, -1, '0, 1'b0, -1, '0, 1'b0, cyc);
      chk("abc_rnd_idle", {63'd0, w_valid}, 64'd0);

      // back-to-back: second block lands on the final handshake
      ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expect_block(ra);
      expect_block(rb);
      load(ra);
      drain(128, 1'b0, 63, rb, 1'b0, -1, '0, 1'b0, cyc);
      chk("b2b_cycles", 64'(cyc), 64'd128);
      chk("b2b_idle", {63'd0, w_valid}, 64'd0);

      // blocks during expansion at t=10 and t=20
      rc = ~rb;
      expect_block(ra);
`ifdef SHA_SCHED_SKID_EN
      expect_block(rb);
      load(ra);
      drain(128, 1'b0, 10, rb, 1'b0, 20, rc, 1'b1, cyc);
`else
      load(ra);
      drain(64, 1'b0, 10, rb, 1'b1, 20, rc, 1'b1, cyc);
`endif
      chk("skid_idle", {63'd0, w_valid}, 64'd0);
      chk("skid_busy", {63'd0, busy}, 64'd0);

      // asynchronous reset mid-expansion at t=30
      expect_block(abc);
      load(abc);
      drain(30, 1'b0, -1, '0, 1'b0, -1, '0, 1'b0, cyc);
      #2 rst = 1'b1;
      #1;
      chk("arst_w_valid", {63'd0, w_valid}, 64'd0);
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_w_idx", {58'd0, w_idx}, 64'd0);
      chk("arst_w_out", {32'd0, w_out}, 64'd0);
      chk("arst_w_last", {63'd0, w_last}, 64'd0);
      exp_q.delete();
      exp_iq.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      expect_block(abc);
      load(abc);
      drain(64, 1'b1, -1, '0, 1'b0, -1, '0, 1'b0, cyc);
      chk("arst_restart_w0", {32'd0, cap[0]}, 64'h61626380);

      // all-ones block exercises carry wrap
      expect_block(ones);
      load(ones);
      drain(64, 1'b0, -1, '0, 1'b0, -1, '0, 1'b0, cyc);
      chk("ones_w16", {32'd0, cap[16]}, 64'h203FFFFC);

      // random blocks under random backpressure
      for (int k = 0; k < 3; k++) begin
         ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         expect_block(ra);
         load(ra);
         drain(64, 1'b1, -1, '0, 1'b0, -1, '0, 1'b0, cyc);
      end
      chk("final_idle", {63'd0, w_valid}, 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
